// File: rtl/r5p_ls_responder.sv
// r5p_ls_responder: memory target for the R5P load/store bus.
// Accepts one read or write per handshake after a number of wait states,
// performs byte-enabled writes into an internal word array and returns
// registered read data one cycle after a read transfer.
// Optional build macro R5P_LS_RESPONDER_RANDWAIT_EN: replaces the fixed wait
// count with a per-request pseudo-random limit in 0..WAIT (LFSR driven).

module r5p_ls_responder #(
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32,
  parameter int unsigned BW   = DW/8,
  parameter int unsigned SIZE = 16384,
  parameter int unsigned WAIT = 0
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            ls_vld,
  input  logic            ls_wen,
  input  logic [AW-1:0]   ls_adr,
  input  logic [BW-1:0]   ls_ben,
  input  logic [BW*8-1:0] ls_wdt,
  output logic [BW*8-1:0] ls_rdt,
  output logic            ls_rdy
);

  // Handshake: a transfer happens in every cycle where ls_vld & ls_rdy.
  // The initiator holds vld/wen/adr/ben/wdt stable from vld rising until the
  // transfer; ls_rdy is a function of registered state only, never of ls_vld.

  localparam int unsigned LB = $clog2(BW);
  localparam int unsigned AB = $clog2(SIZE);
  localparam int unsigned NW = SIZE / BW;
  localparam int unsigned IW = (AB > LB) ? (AB - LB) : 1;

  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       lim;
  logic             xfer;
  logic [IW-1:0]    idx;
  logic [BW*8-1:0]  rdt_q;
  logic [BW*8-1:0]  mem_q [NW];
  logic             unused_adr;

  // Only the word-index bits select storage; everything else aliases.
  generate
    if (AB > LB) begin : g_idx
      assign idx = ls_adr[AB-1:LB];
    end else begin : g_idx_one
      assign idx = '0;
    end
  endgenerate

  assign unused_adr = ^ls_adr;

  assign ls_rdy = (cnt_q == lim);
  assign xfer   = ls_vld & ls_rdy;
  assign ls_rdt = rdt_q;

`ifdef R5P_LS_RESPONDER_RANDWAIT_EN
  localparam logic [4:0]  MOD     = 5'(WAIT + 1);
  localparam logic [15:0] SEED    = 16'hACE1;
  localparam logic [3:0]  LIM_RST = 4'((32'(SEED[3:0])) % (WAIT + 1));

  logic [15:0] lfsr_q, lfsr_d;
  logic [3:0]  lim_q, lim_d;
  logic [3:0]  lim_mod;

  assign lim_mod = 4'({1'b0, lfsr_q[3:0]} % MOD);
  assign lim     = lim_q;

  // LFSR step (taps 16,14,13,11) and per-request limit reload on transfer.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    lim_d  = lim_q;
    if (xfer) begin
      lim_d = lim_mod;
    end
  end

  // LFSR and limit registers; both restart from the seed on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
      lim_q  <= LIM_RST;
    end else begin
      lfsr_q <= lfsr_d;
      lim_q  <= lim_d;
    end
  end
`else
  assign lim = 4'(WAIT);
`endif

  // Wait counter next state: clear on transfer, count while a request waits.
  always_comb begin
    cnt_d = cnt_q;
    if (xfer) begin
      cnt_d = '0;
    end else if (ls_vld) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Wait counter register; reset abandons any pending request.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Byte-enabled write into the array; contents are never reset and a
  // write presented during reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && xfer && ls_wen) begin
      for (int i = 0; i < BW; i++) begin
        if (ls_ben[i]) begin
          mem_q[idx][8*i +: 8] <= ls_wdt[8*i +: 8];
        end
      end
    end
  end

  // Read data register: loads the whole word on a read transfer, holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdt_q <= '0;
    end else if (xfer && !ls_wen) begin
      rdt_q <= mem_q[idx];
    end
  end

endmodule

// File: tb/tb_r5p_ls_responder.sv
// Bench for r5p_ls_responder: two instances (WAIT=0 and WAIT=3) driven by
// directed and random traffic, checked every cycle against a byte-level
// behavioural model of the bus target.

module tb_r5p_ls_responder;

  localparam int SIZE = 16384;
  localparam int NWRD = SIZE / 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        vld [2];
  logic        wen [2];
  logic [31:0] adr [2];
  logic [3:0]  ben [2];
  logic [31:0] wdt [2];
  logic [31:0] rdt [2];
  logic        rdy [2];

  r5p_ls_responder #(.WAIT(0)) u_w0 (
    .clk(clk), .rst(rst), .ls_vld(vld[0]), .ls_wen(wen[0]), .ls_adr(adr[0]),
    .ls_ben(ben[0]), .ls_wdt(wdt[0]), .ls_rdt(rdt[0]), .ls_rdy(rdy[0])
  );

  r5p_ls_responder #(.WAIT(3)) u_w3 (
    .clk(clk), .rst(rst), .ls_vld(vld[1]), .ls_wen(wen[1]), .ls_adr(adr[1]),
    .ls_ben(ben[1]), .ls_wdt(wdt[1]), .ls_rdt(rdt[1]), .ls_rdy(rdy[1])
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  function automatic int wt(int k);
    return (k == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got=%h exp=%h t=%0t", name, k, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem  [2][NWRD];
  bit          m_def  [2][NWRD];
  int          m_wait [2] = '{0, 0};
  logic [31:0] m_rdt  [2] = '{32'h0, 32'h0};
  bit          m_ok   [2] = '{1'b1, 1'b1};
`ifdef R5P_LS_RESPONDER_RANDWAIT_EN
  logic [15:0] m_lfsr [2] = '{16'hACE1, 16'hACE1};
  int          m_lim  [2] = '{0, 1};
`endif

  function automatic bit exp_rdy(int k);
`ifdef R5P_LS_RESPONDER_RANDWAIT_EN
    return m_wait[k] == m_lim[k];
`else
    return m_wait[k] == wt(k);
`endif
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit x;
      int wi;
      x  = vld[k] && exp_rdy(k);
      wi = int'(adr[k] % SIZE) / 4;
      if (rst) begin
        m_wait[k] = 0;
        m_rdt[k]  = 32'h0;
        m_ok[k]   = 1'b1;
`ifdef R5P_LS_RESPONDER_RANDWAIT_EN
        m_lfsr[k] = 16'hACE1;
        m_lim[k]  = 1 % (wt(k) + 1);
`endif
      end else begin
        if (x) begin
          if (wen[k]) begin
            for (int b = 0; b < 4; b++)
              if (ben[k][b]) m_mem[k][wi][8*b +: 8] = wdt[k][8*b +: 8];
            if (ben[k] == 4'hF) m_def[k][wi] = 1'b1;
          end else begin
            m_rdt[k] = m_mem[k][wi];
            m_ok[k]  = m_def[k][wi];
          end
          m_wait[k] = 0;
`ifdef R5P_LS_RESPONDER_RANDWAIT_EN
          m_lim[k] = int'(m_lfsr[k][3:0]) % (wt(k) + 1);
`endif
        end else if (vld[k]) begin
          m_wait[k]++;
        end
`ifdef R5P_LS_RESPONDER_RANDWAIT_EN
        m_lfsr[k] = {m_lfsr[k][14:0],
                     m_lfsr[k][15] ^ m_lfsr[k][13] ^ m_lfsr[k][12] ^ m_lfsr[k][10]};
`endif
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("rdy", k, 32'(rdy[k]), 32'(exp_rdy(k)));
        if (m_ok[k]) chk("rdt", k, rdt[k], m_rdt[k]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Waits (bounded) for ls_rdy while the request is held; returns wait cycles.
  task automatic wait_rdy(input int k, output int n);
    bit got;
    n   = 0;
    got = 0;
    while (!got && n <= 40) begin
      @(negedge clk);
      if (rdy[k] === 1'b1) got = 1;
      else n++;
    end
    chk("handshake", k, 32'(got), 32'd1);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the transfer edge.
  task automatic xfer(input int k, input bit w, input logic [31:0] a,
                      input logic [3:0] be, input logic [31:0] d);
    int n;
    vld[k] = 1'b1; wen[k] = w; adr[k] = a; ben[k] = be; wdt[k] = d;
    wait_rdy(k, n);
`ifdef R5P_LS_RESPONDER_RANDWAIT_EN
    chk("wait_le", k, 32'(n <= wt(k)), 32'd1);
`else
    chk("wait", k, 32'(n), 32'(wt(k)));
`endif
    @(posedge clk); #1;
    vld[k] = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      vld[k] = 1'b0; wen[k] = 1'b0; adr[k] = '0; ben[k] = '0; wdt[k] = '0;
    end
    @(posedge clk);
    chk_en = 1;
    @(negedge clk);
    chk("rst_rdy", 0, 32'(rdy[0]), 32'd1);
    chk("rst_rdy", 1, 32'(rdy[1]), 32'd0);
    chk("rst_rdt", 0, rdt[0], 32'h0);
    chk("rst_rdt", 1, rdt[1], 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Back-to-back write then read, partial write, alias read (WAIT=0).
    xfer(0, 1, 32'h10, 4'hF, 32'hDEADBEEF);
    xfer(0, 0, 32'h10, 4'hF, 32'h0);
    chk("lit_full", 0, rdt[0], 32'hDEADBEEF);
    xfer(0, 1, 32'h10, 4'b0010, 32'h0000AA00);
    xfer(0, 0, 32'h10, 4'b0000, 32'h0);
    chk("lit_lane", 0, rdt[0], 32'hDEADAAEF);
    xfer(0, 1, 32'h20, 4'hF, 32'h12345678);
    xfer(0, 0, 32'h4020, 4'hF, 32'h0);
    chk("lit_alias", 0, rdt[0], 32'h12345678);

    // Held read on the WAIT=3 instance.
    xfer(1, 1, 32'h10, 4'hF, 32'hA5A50F0F);
    xfer(1, 0, 32'h10, 4'hF, 32'h0);
    chk("lit_wait_rd", 1, rdt[1], 32'hA5A50F0F);

    // Reset in the middle of a pending write; concurrent write during reset.
    vld[1] = 1'b1; wen[1] = 1'b1; adr[1] = 32'h40; ben[1] = 4'hF; wdt[1] = 32'hCAFEF00D;
    @(posedge clk); #1;
    rst = 1'b1;
    vld[0] = 1'b1; wen[0] = 1'b1; adr[0] = 32'h10; ben[0] = 4'hF; wdt[0] = 32'h11111111;
    @(posedge clk); #1;
    rst = 1'b0;
    vld[0] = 1'b0;
    wait_rdy(1, n);
`ifndef R5P_LS_RESPONDER_RANDWAIT_EN
    chk("rst_rewait", 1, 32'(n), 32'd3);
`endif
    @(posedge clk); #1;
    vld[1] = 1'b0;
    xfer(1, 0, 32'h40, 4'hF, 32'h0);
    chk("lit_rst_wr", 1, rdt[1], 32'hCAFEF00D);
    xfer(0, 0, 32'h10, 4'hF, 32'h0);
    chk("lit_rst_nowr", 0, rdt[0], 32'hDEADAAEF);

    // Random traffic over a small aliased working set.
    for (int w = 0; w < 8; w++)
      for (int k = 0; k < 2; k++)
        xfer(k, 1, 32'h100 + 32'(w*4), 4'hF, $urandom);
    for (int i = 0; i < 600; i++) begin
      int k, w;
      bit we;
      logic [31:0] a;
      k  = $urandom_range(0, 1);
      w  = $urandom_range(0, 7);
      we = 1'($urandom_range(0, 1));
      a  = 32'h100 + 32'(w*4) + 32'($urandom_range(0, 3)) + 32'(SIZE * $urandom_range(0, 15));
      if (we) xfer(k, 1'b1, a, 4'($urandom_range(1, 15)), $urandom);
      else    xfer(k, 1'b0, a, 4'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
